// File: rtl/msg_pad_pkg.sv
// Shared types and helpers for the message pad/align datapath.
// Used by msg_pad_aligner and msg_byte_shifter.
package msg_pad_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFlush,
    StFill
  } state_e;

  localparam logic [7:0] FINAL_BIT = 8'h80;
  localparam int unsigned MAX_BYTES = 16;

  // Bit i set for the first nbytes bytes of a word (byte 0 = MSB byte).
  function automatic logic [MAX_BYTES-1:0] lead_byte_en(input int unsigned nbytes);
    logic [MAX_BYTES-1:0] en;
    en = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      en[i] = (i < nbytes);
    end
    return en;
  endfunction

  // Width needed to hold a byte count in 0..bytes.
  function automatic int unsigned cnt_bits(input int unsigned bytes);
    return $clog2(bytes) + 1;
  endfunction

endpackage

// File: rtl/msg_byte_shifter.sv
// Combinational merge of a left-aligned residue with a left-aligned input word.
// Produces the next full word (hi), the spill-over (lo) and the total byte count.
module msg_byte_shifter
  import msg_pad_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  localparam int unsigned BYTES = DATA_W / 8,
  localparam int unsigned CNT_W = $clog2(DATA_W / 8) + 1
) (
  input  logic [DATA_W-1:0] res_data_i,
  input  logic [CNT_W-1:0]  res_cnt_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CNT_W-1:0]  in_cnt_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [CNT_W-1:0]  total_o
);

  logic [BYTES-1:0]    res_en;
  logic [BYTES-1:0]    in_en;
  logic [DATA_W-1:0]   res_m;
  logic [DATA_W-1:0]   in_m;
  logic [2*DATA_W-1:0] stream;

  always_comb begin
    res_en = BYTES'(lead_byte_en(32'(res_cnt_i)));
    in_en  = BYTES'(lead_byte_en(32'(in_cnt_i)));
    res_m  = '0;
    in_m   = '0;
    // Bytes past each count are forced to zero so the packed stream stays clean.
    for (int unsigned i = 0; i < BYTES; i++) begin
      res_m[DATA_W-1-8*i -: 8] = res_data_i[DATA_W-1-8*i -: 8] & {8{res_en[i]}};
      in_m[DATA_W-1-8*i -: 8]  = in_data_i[DATA_W-1-8*i -: 8] & {8{in_en[i]}};
    end
    stream  = {res_m, {DATA_W{1'b0}}} | ({in_m, {DATA_W{1'b0}}} >> (8 * res_cnt_i));
    hi_o    = stream[2*DATA_W-1:DATA_W];
    lo_o    = stream[DATA_W-1:0];
    total_o = res_cnt_i + in_cnt_i;
  end

endmodule

// File: rtl/msg_pad_aligner.sv
// Prefixes, byte-aligns and pads a message stream into DATA_W-bit sponge words.
// Define MSG_PAD_RATE_FILL_EN to zero-fill to the rate block and set the final 8'h80 bit.
module msg_pad_aligner
  import msg_pad_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned RATE_WORDS = 17,
  parameter logic [7:0]  PAD_BYTE   = 8'h1F
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [DATA_W-1:0]            s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         s_last,
  input  logic [$clog2(DATA_W/8):0]    s_nbytes,
  input  logic [DATA_W-9:0]            pre_data,
  input  logic [$clog2(DATA_W/8)-1:0]  pre_len,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned CNT_W  = cnt_bits(BYTES);
  localparam int unsigned WCNT_W = $clog2(RATE_WORDS);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(RATE_WORDS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(BYTES);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;
  logic                pad_q, pad_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;

  logic [DATA_W-1:0]   sh_res, sh_in, sh_hi, sh_lo;
  logic [CNT_W-1:0]    sh_res_cnt, sh_in_cnt, sh_total, nb;
  logic                out_free, accept;
  logic                ld, ld_last, msg_done;
  logic [DATA_W-1:0]   ld_word;

  assign out_free = ~m_valid_q | m_ready;
  assign s_ready  = rstn & out_free & ((state_q == StIdle) | (state_q == StStream));
  assign accept   = s_valid & s_ready;
  assign nb       = (s_nbytes > FULL_CNT) ? FULL_CNT : s_nbytes;

  // In IDLE the residue slot carries the prefix; in FLUSH the input slot carries the pad byte.
  always_comb begin
    sh_res     = res_q;
    sh_res_cnt = res_cnt_q;
    sh_in      = s_data;
    sh_in_cnt  = s_last ? nb : FULL_CNT;
    if (state_q == StIdle) begin
      sh_res     = {pre_data, 8'h00};
      sh_res_cnt = CNT_W'(pre_len);
    end else if (state_q == StFlush) begin
      sh_in     = {PAD_BYTE, {(DATA_W-8){1'b0}}};
      sh_in_cnt = pad_q ? '0 : CNT_W'(1);
    end
  end

  msg_byte_shifter #(
    .DATA_W(DATA_W)
  ) u_shifter (
    .res_data_i(sh_res),
    .res_cnt_i (sh_res_cnt),
    .in_data_i (sh_in),
    .in_cnt_i  (sh_in_cnt),
    .hi_o      (sh_hi),
    .lo_o      (sh_lo),
    .total_o   (sh_total)
  );

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    res_cnt_d = res_cnt_q;
    pad_d     = pad_q;
    wcnt_d    = wcnt_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q & ~m_ready;
    m_last_d  = m_last_q & m_valid_d;
    ld        = 1'b0;
    ld_word   = sh_hi;
    ld_last   = 1'b0;
    msg_done  = 1'b0;

    unique case (state_q)
      StIdle, StStream: begin
        if (accept) begin
          state_d = s_last ? StFlush : StStream;
          pad_d   = 1'b0;
          if (sh_total >= FULL_CNT) begin
            ld        = 1'b1;
            res_d     = sh_lo;
            res_cnt_d = sh_total - FULL_CNT;
          end else begin
            res_d     = sh_hi;
            res_cnt_d = sh_total;
          end
        end
      end

      StFlush: begin
        if (out_free) begin
          ld = 1'b1;
          if (!pad_q && (sh_total > FULL_CNT)) begin
            // Pad byte spills past a full residue word: emit it on a second flush word.
            res_d     = sh_lo;
            res_cnt_d = sh_total - FULL_CNT;
            pad_d     = 1'b1;
          end else begin
            res_d     = '0;
            res_cnt_d = '0;
            pad_d     = 1'b0;
`ifdef MSG_PAD_RATE_FILL_EN
            if (wcnt_q == LAST_WORD) begin
              ld_word[7:0] = sh_hi[7:0] | FINAL_BIT;
              ld_last      = 1'b1;
              msg_done     = 1'b1;
              state_d      = StIdle;
            end else begin
              state_d = StFill;
            end
`else
            ld_last  = 1'b1;
            msg_done = 1'b1;
            state_d  = StIdle;
`endif
          end
        end
      end

`ifdef MSG_PAD_RATE_FILL_EN
      StFill: begin
        if (m_valid_q && m_last_q) begin
          if (m_ready) state_d = StIdle;
        end else if (out_free) begin
          ld      = 1'b1;
          ld_word = '0;
          if (wcnt_q == LAST_WORD) begin
            ld_word[7:0] = FINAL_BIT;
            ld_last      = 1'b1;
            msg_done     = 1'b1;
          end
        end
      end
`endif

      default: state_d = StIdle;
    endcase

    if (ld) begin
      m_valid_d = 1'b1;
      m_data_d  = ld_word;
      m_last_d  = ld_last;
      wcnt_d    = (wcnt_q == LAST_WORD) ? '0 : wcnt_q + 1'b1;
    end
    if (msg_done) wcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      res_q     <= '0;
      res_cnt_q <= '0;
      pad_q     <= 1'b0;
      wcnt_q    <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      res_cnt_q <= res_cnt_d;
      pad_q     <= pad_d;
      wcnt_q    <= wcnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_msg_pad_aligner.sv
// Bench for msg_pad_aligner: byte-queue reference model, random throttling, directed cases.
module tb_msg_pad_aligner;

  localparam int DATA_W = 64;
  localparam int BYTES  = 8;
  localparam int RATE   = 17;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [3:0]  s_nbytes;
  logic [55:0] pre_data;
  logic [2:0]  pre_len;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  always #5 clk = ~clk;

  msg_pad_aligner #(
    .DATA_W    (DATA_W),
    .RATE_WORDS(RATE),
    .PAD_BYTE  (8'h1F)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .s_nbytes(s_nbytes),
    .pre_data(pre_data),
    .pre_len (pre_len),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last)
  );

  int          n_cmp;
  int          n_bad;
  logic [63:0] exp_q[$];
  bit          last_q[$];
  logic [63:0] first_w;
  logic [63:0] second_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One message: prefix + message bytes, expected output built from the padding rule.
  task automatic run_msg(input int pre_l, input int nfull, input int last_nb, input int pv,
                         input int pr, input int stall_cyc, input int abort_after,
                         input bit fixed);
    byte unsigned msg[$];
    byte unsigned all[$];
    logic [55:0]  pd;
    logic [63:0]  w;
    logic [63:0]  d;
    bit           l, vld, lst, fire_s, fire_m;
    int           nbeats, beat, nw, idx, n_out;

    pd = fixed ? 56'hAABBCCDDEEFF11 : {$urandom(), 24'($urandom())};
    for (int i = 0; i < pre_l; i++) all.push_back(pd[55-8*i -: 8]);
    for (int i = 0; i < nfull * BYTES + last_nb; i++) begin
      msg.push_back(fixed ? 8'(8'h11 * i) : 8'($urandom()));
      all.push_back(msg[i]);
    end
    all.push_back(8'h1F);
    while (all.size() % BYTES != 0) all.push_back(8'h00);
`ifdef MSG_PAD_RATE_FILL_EN
    while ((all.size() / BYTES) % RATE != 0) all.push_back(8'h00);
    all[all.size()-1] = all[all.size()-1] | 8'h80;
`endif
    nw = all.size() / BYTES;
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < BYTES; j++) w[63-8*j -: 8] = all[k*BYTES+j];
      exp_q.push_back(w);
      last_q.push_back(k == nw - 1);
    end

    pre_data = pd;
    pre_len  = 3'(pre_l);
    nbeats   = nfull + 1;
    beat     = 0;
    n_out    = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (beat >= nbeats && exp_q.size() == 0) break;
      s_valid  = (beat < nbeats) && ($urandom_range(99) < pv);
      s_last   = (beat == nbeats - 1);
      s_nbytes = s_last ? 4'(last_nb) : 4'($urandom_range(8));
      for (int j = 0; j < BYTES; j++) begin
        idx = beat * BYTES + j;
        s_data[63-8*j -: 8] = (idx < msg.size()) ? msg[idx] : 8'($urandom());
      end
      m_ready = (cyc >= stall_cyc && cyc < stall_cyc + 3) ? 1'b0 : ($urandom_range(99) < pr);
      #1;
      if (m_valid && !m_ready) chk("s_ready_backpressure", 64'(s_ready), 64'd0);
      vld    = m_valid;
      d      = m_data;
      lst    = m_last;
      fire_s = s_valid && s_ready;
      fire_m = m_valid && m_ready;
      @(posedge clk);
      #1;
      if (fire_s) beat++;
      if (fire_m) begin
        n_out++;
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          l = last_q.pop_front();
          chk($sformatf("m_data[%0d]", n_out - 1), d, w);
          chk($sformatf("m_last[%0d]", n_out - 1), 64'(lst), 64'(l));
        end
        if (n_out == 1) first_w = d;
        if (n_out == 2) second_w = d;
        if (abort_after > 0 && n_out == abort_after) return;
      end else if (vld) begin
        chk("hold_m_data", m_data, d);
        chk("hold_m_valid", 64'(m_valid), 64'd1);
        chk("hold_m_last", 64'(m_last), 64'(lst));
      end
    end
    chk("word_count", 64'(n_out), 64'(nw));
    chk("beats_sent", 64'(beat), 64'(nbeats));
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rstn     = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    s_nbytes = '0;
    pre_data = '0;
    pre_len  = '0;
    m_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_m_last", 64'(m_last), 64'd0);
    chk("reset_m_data", m_data, 64'd0);
    chk("reset_s_ready", 64'(s_ready), 64'd0);
    rstn    = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("idle_s_ready", 64'(s_ready), 64'd1);

    // Prefix AABB + one full last word.
    run_msg(2, 0, 8, 100, 100, -1, 0, 1'b1);
    chk("prefix_word0", first_w, 64'hAABB001122334455);
    chk("prefix_word1", second_w, 64'h66771F0000000000);

    // Empty message.
    run_msg(0, 0, 0, 100, 100, -1, 0, 1'b0);
    chk("empty_word0", first_w, 64'h1F00000000000000);

    // Pad lands in the final byte of the rate block.
    run_msg(0, 16, 7, 100, 100, -1, 0, 1'b0);

    // Longer than one rate block: counter wraps.
    run_msg(0, 19, 8, 80, 90, -1, 0, 1'b0);

    // Downstream stall mid-stream.
    run_msg(3, 6, 5, 100, 100, 4, 0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      run_msg($urandom_range(7), $urandom_range(20), $urandom_range(8),
              $urandom_range(100, 50), $urandom_range(100, 40), -1, 0, 1'b0);
    end

    // Reset while zero-filling; nothing of the aborted message may appear afterwards.
    run_msg(0, 2, 3, 100, 100, -1, 5, 1'b0);
    s_valid = 1'b0;
    rstn    = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_m_valid", 64'(m_valid), 64'd0);
    chk("abort_m_last", 64'(m_last), 64'd0);
    chk("abort_m_data", m_data, 64'd0);
    rstn = 1'b1;
    exp_q.delete();
    last_q.delete();
    run_msg(1, 3, 4, 90, 90, -1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
